// File: rtl/mining_pkg.sv
// -----------------------------------------------------------------------------
// mining_pkg
// Definitions shared by the nonce scheduler and the mining control logic.
// It holds the scheduler state encoding, the default nonce width and difficulty,
// and the 256-bit digest width that Mining_FSM also uses.
// -----------------------------------------------------------------------------
package mining_pkg;

    localparam int NONCE_W_DEF   = 32;
    localparam int DIFF_BITS_DEF = 10;
    localparam int HASH_W        = 256;
    localparam int ATTEMPT_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_CHECK     = 3'd3,
        ST_FOUND     = 3'd4,
        ST_EXHAUSTED = 3'd5
    } state_e;

    // A new sweep may only begin from a resting state.
    function automatic logic start_allowed(input state_e s);
        return (s == ST_IDLE) || (s == ST_FOUND) || (s == ST_EXHAUSTED);
    endfunction

    // The scheduler is busy while a candidate is outstanding or being judged.
    function automatic logic is_busy(input state_e s);
        return (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/difficulty_check.sv
// -----------------------------------------------------------------------------
// difficulty_check
// Purely combinational hit test. A digest is a hit when its DIFF_BITS most
// significant bits are all zero.
// Ports:
//   HASH  in  [HASH_W-1:0]  digest, bit HASH_W-1 is the MSB
//   hit   out               1 when HASH[HASH_W-1 -: DIFF_BITS] == 0
// -----------------------------------------------------------------------------
module difficulty_check
    import mining_pkg::*;
#(
    parameter int DIFF_BITS = DIFF_BITS_DEF
) (
    input  logic [HASH_W-1:0] HASH,
    output logic              hit
);

    // Mask that selects the leading DIFF_BITS bits of the digest. Shifting an
    // all-ones word right and inverting it avoids a zero-width replication
    // when DIFF_BITS equals HASH_W.
    localparam logic [HASH_W-1:0] LEAD_MASK = ~({HASH_W{1'b1}} >> DIFF_BITS);

    logic [HASH_W-1:0] lead_bits;

    assign lead_bits = HASH & LEAD_MASK;
    assign hit       = ~|lead_bits;

endmodule

// File: rtl/nonce_scheduler.sv
// -----------------------------------------------------------------------------
// nonce_scheduler
// Sweeps an inclusive nonce range, presents one candidate at a time to a hash
// core with a valid/ready handshake, waits for the digest, and stops on the
// first digest that meets the difficulty or when the range is used up.
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   start, abort        control pulses (abort has priority over everything but reset)
//   nonce_first/last    inclusive range, sampled on an accepted start
//   nonce_valid/ready   candidate handshake toward the hash core
//   nonce               current candidate
//   hash_valid, HASH    digest for the last transferred candidate
//   busy/found/exhausted  status flags derived from the state
//   found_nonce         winning nonce, meaningful while found is high
//   attempts            digests checked in the current sweep (saturating)
// -----------------------------------------------------------------------------
module nonce_scheduler
    import mining_pkg::*;
#(
    parameter int NONCE_W   = NONCE_W_DEF,
    parameter int DIFF_BITS = DIFF_BITS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NONCE_W-1:0]   nonce_first,
    input  logic [NONCE_W-1:0]   nonce_last,
    output logic                 nonce_valid,
    input  logic                 nonce_ready,
    output logic [NONCE_W-1:0]   nonce,
    input  logic                 hash_valid,
    input  logic [HASH_W-1:0]    HASH,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [NONCE_W-1:0]   found_nonce,
    output logic [ATTEMPT_W-1:0] attempts
);

    state_e                 state_q, state_d;
    logic [NONCE_W-1:0]     nonce_q, nonce_d;
    logic [NONCE_W-1:0]     last_q, last_d;
    logic [NONCE_W-1:0]     found_nonce_q, found_nonce_d;
    logic [ATTEMPT_W-1:0]   attempts_q, attempts_d;
    logic                   hit_q, hit_d;

    logic                   hash_hit;
    logic                   start_ok;

    difficulty_check #(
        .DIFF_BITS (DIFF_BITS)
    ) u_difficulty_check (
        .HASH (HASH),
        .hit  (hash_hit)
    );

    assign start_ok = start && start_allowed(state_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            nonce_q       <= '0;
            last_q        <= '0;
            found_nonce_q <= '0;
            attempts_q    <= '0;
            hit_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            last_q        <= last_d;
            found_nonce_q <= found_nonce_d;
            attempts_q    <= attempts_d;
            hit_q         <= hit_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        nonce_d       = nonce_q;
        last_d        = last_q;
        found_nonce_d = found_nonce_q;
        attempts_d    = attempts_q;
        hit_d         = hit_q;

        if (abort) begin
            // Attempts and the candidate are deliberately kept so software can
            // see how far the cancelled sweep got.
            state_d = ST_IDLE;
        end else if (start_ok) begin
            nonce_d       = nonce_first;
            last_d        = nonce_last;
            attempts_d    = '0;
            found_nonce_d = '0;
            state_d       = (nonce_first > nonce_last) ? ST_EXHAUSTED : ST_ISSUE;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    if (nonce_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (hash_valid) begin
                        hit_d   = hash_hit;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (attempts_q != '1) begin
                        attempts_d = attempts_q + 32'd1;
                    end
                    // The end-of-range test uses the un-incremented nonce so an
                    // all-ones last nonce stops instead of wrapping to zero.
                    if (hit_q) begin
                        found_nonce_d = nonce_q;
                        state_d       = ST_FOUND;
                    end else if (nonce_q == last_q) begin
                        state_d = ST_EXHAUSTED;
                    end else begin
                        nonce_d = nonce_q + NONCE_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign nonce_valid = (state_q == ST_ISSUE);
    assign nonce       = nonce_q;
    assign busy        = is_busy(state_q);
    assign found       = (state_q == ST_FOUND);
    assign exhausted   = (state_q == ST_EXHAUSTED);
    assign found_nonce = found_nonce_q;
    assign attempts    = attempts_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nonce_scheduler
// Directed bench for nonce_scheduler with hand-computed expectations. The bench
// plays the hash core itself, one line per candidate transfer.
// -----------------------------------------------------------------------------
module tb_nonce_scheduler;

    localparam int NW = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic            abort;
    logic [NW-1:0]   nonce_first;
    logic [NW-1:0]   nonce_last;
    logic            nonce_valid;
    logic            nonce_ready;
    logic [NW-1:0]   nonce;
    logic            hash_valid;
    logic [255:0]    HASH;
    logic            busy;
    logic            found;
    logic            exhausted;
    logic [NW-1:0]   found_nonce;
    logic [31:0]     attempts;

    // Top 10 bits zero, remaining bits one: just meets the default difficulty.
    logic [255:0]    hit_hash;
    logic [255:0]    miss_hash;

    int checks_total  = 0;
    int checks_passed = 0;

    nonce_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .nonce_first (nonce_first),
        .nonce_last  (nonce_last),
        .nonce_valid (nonce_valid),
        .nonce_ready (nonce_ready),
        .nonce       (nonce),
        .hash_valid  (hash_valid),
        .HASH        (HASH),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .found_nonce (found_nonce),
        .attempts    (attempts)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Runs one sweep with ready held high, answering every transfer with a
    // miss digest except hit_n (when use_hit is set).
    task automatic sweep(input logic [NW-1:0] first, input logic [NW-1:0] last,
                         input logic use_hit, input logic [NW-1:0] hit_n,
                         output int xfers, output logic saw_zero);
        logic          done;
        logic          hit_now;
        logic [NW-1:0] n;
        xfers       = 0;
        saw_zero    = 1'b0;
        done        = 1'b0;
        nonce_ready = 1'b1;
        nonce_first = first;
        nonce_last  = last;
        start       = 1'b1;
        tick;
        start = 1'b0;
        check("start_to_valid", {63'd0, nonce_valid}, 64'd1);
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (found || exhausted) begin
                done = 1'b1;
            end else if (nonce_valid) begin
                n = nonce;
                xfers++;
                if (n == '0) saw_zero = 1'b1;
                $display("transfer nonce=%08h", n);
                tick;
                hit_now    = use_hit && (n == hit_n);
                hash_valid = 1'b1;
                HASH       = hit_now ? hit_hash : miss_hash;
                tick;
                hash_valid = 1'b0;
                HASH       = miss_hash;
                tick;
                check("hv_to_valid", {63'd0, nonce_valid}, {63'd0, !(hit_now || n == last)});
            end else begin
                tick;
            end
        end
        check("sweep_done", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int   xfers;
        logic saw_zero;

        hit_hash    = {256{1'b1}} >> 10;
        miss_hash   = {256{1'b1}};
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        nonce_first = '0;
        nonce_last  = '0;
        nonce_ready = 1'b0;
        hash_valid  = 1'b0;
        HASH        = miss_hash;
        tick;
        tick;
        reset = 1'b0;

        // Reset state
        check("rst_nonce_valid", {63'd0, nonce_valid}, 64'd0);
        check("rst_busy",        {63'd0, busy},        64'd0);
        check("rst_found",       {63'd0, found},       64'd0);
        check("rst_exhausted",   {63'd0, exhausted},   64'd0);
        check("rst_nonce",       {32'd0, nonce},       64'd0);
        check("rst_attempts",    {32'd0, attempts},    64'd0);

        // Range 5..7, hit on the last nonce
        sweep(32'd5, 32'd7, 1'b1, 32'd7, xfers, saw_zero);
        check("t1_found",       {63'd0, found},       64'd1);
        check("t1_exhausted",   {63'd0, exhausted},   64'd0);
        check("t1_found_nonce", {32'd0, found_nonce}, 64'd7);
        check("t1_attempts",    {32'd0, attempts},    64'd3);
        check("t1_xfers",       64'(xfers),           64'd3);
        check("t1_busy",        {63'd0, busy},        64'd0);

        // Range 0..2, no hits
        sweep(32'd0, 32'd2, 1'b0, 32'd0, xfers, saw_zero);
        check("t2_exhausted", {63'd0, exhausted}, 64'd1);
        check("t2_found",     {63'd0, found},     64'd0);
        check("t2_attempts",  {32'd0, attempts},  64'd3);
        check("t2_xfers",     64'(xfers),         64'd3);
        check("t2_found_nonce_clr", {32'd0, found_nonce}, 64'd0);
        tick;
        tick;
        tick;
        check("t2_hold", {63'd0, exhausted}, 64'd1);

        // Top of the nonce space, must not wrap
        sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'd0, xfers, saw_zero);
        check("t3_exhausted", {63'd0, exhausted}, 64'd1);
        check("t3_xfers",     64'(xfers),         64'd2);
        check("t3_no_zero",   {63'd0, saw_zero},  64'd0);
        check("t3_nonce",     {32'd0, nonce},     64'hFFFF_FFFF);
        check("t3_attempts",  {32'd0, attempts},  64'd2);

        // Back-pressure: ready low 4 cycles, stray hash_valid in ISSUE
        nonce_ready = 1'b0;
        nonce_first = 32'd20;
        nonce_last  = 32'd20;
        start       = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t4_valid_held", {63'd0, nonce_valid}, 64'd1);
            check("t4_nonce_held", {32'd0, nonce},       64'd20);
            hash_valid = (i == 1);
            HASH       = (i == 1) ? hit_hash : miss_hash;
            tick;
        end
        hash_valid  = 1'b0;
        HASH        = miss_hash;
        check("t4_valid_pre", {63'd0, nonce_valid}, 64'd1);
        nonce_ready = 1'b1;
        $display("transfer nonce=%08h", nonce);
        tick;
        nonce_ready = 1'b0;
        check("t4_valid_low", {63'd0, nonce_valid}, 64'd0);
        check("t4_busy",      {63'd0, busy},        64'd1);
        tick;
        check("t4_no_retransfer", {63'd0, nonce_valid}, 64'd0);
        hash_valid = 1'b1;
        tick;
        hash_valid = 1'b0;
        tick;
        check("t4_exhausted", {63'd0, exhausted}, 64'd1);
        check("t4_found",     {63'd0, found},     64'd0);
        check("t4_attempts",  {32'd0, attempts},  64'd1);

        // Start ignored while busy; abort in WAIT beats a hitting hash_valid
        nonce_ready = 1'b1;
        nonce_first = 32'd0;
        nonce_last  = 32'd5;
        start       = 1'b1;
        tick;
        nonce_first = 32'd40;
        nonce_last  = 32'd50;
        $display("transfer nonce=%08h", nonce);
        tick;
        start      = 1'b0;
        hash_valid = 1'b1;
        tick;
        hash_valid = 1'b0;
        tick;
        check("t5_start_ignored", {32'd0, nonce},    64'd1);
        check("t5_attempts_mid",  {32'd0, attempts}, 64'd1);
        $display("transfer nonce=%08h", nonce);
        tick;
        abort      = 1'b1;
        hash_valid = 1'b1;
        HASH       = hit_hash;
        tick;
        abort      = 1'b0;
        hash_valid = 1'b0;
        HASH       = miss_hash;
        check("t5_abort_busy",  {63'd0, busy},        64'd0);
        check("t5_abort_found", {63'd0, found},       64'd0);
        check("t5_abort_valid", {63'd0, nonce_valid}, 64'd0);
        check("t5_abort_attempts", {32'd0, attempts}, 64'd1);
        tick;
        check("t5_idle_stays", {63'd0, busy}, 64'd0);
        nonce_first = 32'd9;
        nonce_last  = 32'd3;
        start       = 1'b1;
        tick;
        start = 1'b0;
        check("t5_empty_exhausted", {63'd0, exhausted},   64'd1);
        check("t5_empty_attempts",  {32'd0, attempts},    64'd0);
        check("t5_empty_valid",     {63'd0, nonce_valid}, 64'd0);

        // Reset while in CHECK
        nonce_ready = 1'b1;
        nonce_first = 32'd3;
        nonce_last  = 32'd5;
        start       = 1'b1;
        tick;
        start = 1'b0;
        $display("transfer nonce=%08h", nonce);
        tick;
        hash_valid = 1'b1;
        tick;
        hash_valid = 1'b0;
        tick;
        $display("transfer nonce=%08h", nonce);
        tick;
        hash_valid = 1'b1;
        tick;
        hash_valid = 1'b0;
        check("t6_in_check", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        start = 1'b1;
        tick;
        reset = 1'b0;
        start = 1'b0;
        check("t6_nonce_valid", {63'd0, nonce_valid}, 64'd0);
        check("t6_busy",        {63'd0, busy},        64'd0);
        check("t6_found",       {63'd0, found},       64'd0);
        check("t6_exhausted",   {63'd0, exhausted},   64'd0);
        check("t6_nonce",       {32'd0, nonce},       64'd0);
        check("t6_found_nonce", {32'd0, found_nonce}, 64'd0);
        check("t6_attempts",    {32'd0, attempts},    64'd0);
        tick;
        check("t6_stays_idle", {63'd0, nonce_valid}, 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
